// File: rtl/mem_pkg.sv
// Shared widths, operand slot indices and the static-field record for the memory issue queue.
package mem_pkg;

  localparam int unsigned TAG_W      = 5;
  localparam int unsigned ROB_W      = 5;
  localparam int unsigned VAL_W      = 8;
  localparam int unsigned NUM_OPS    = 3;
  localparam int unsigned OP_BASE_LO = 0;
  localparam int unsigned OP_BASE_HI = 1;
  localparam int unsigned OP_DATA    = 2;
  localparam int unsigned STORE_BIT  = 0;

  // Fields carried unchanged from dispatch to issue.
  typedef struct packed {
    logic [3:0]       opcode;
    logic [ROB_W-1:0] rob;
    logic [3:0]       imm;
    logic [7:0]       offset;
    logic [4:0]       dest_reg;
    logic [7:0]       dest_arch;
  } iq_static_t;

  function automatic logic cdb_hit(input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] tag);
    return cdb_valid && (cdb_tag == tag);
  endfunction

  function automatic logic is_store(input logic [3:0] opcode);
    return opcode[STORE_BIT];
  endfunction

endpackage

// File: rtl/mem_iq_operand.sv
// One source-operand slot: tag, captured value and ready bit, with same-cycle CDB bypass at write.
module mem_iq_operand
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_valid,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_rdy,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [VAL_W-1:0] cdb_data,
  output logic [VAL_W-1:0] val,
  output logic             rdy
);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic             rdy_q, rdy_d;

  // Dispatch write (with bypass against the current broadcast) or wakeup capture.
  always_comb begin
    tag_d = tag_q;
    val_d = val_q;
    rdy_d = rdy_q;
    if (wr_en) begin
      tag_d = wr_tag;
      if (wr_rdy) begin
        rdy_d = 1'b1;
        val_d = wr_val;
      end else if (cdb_hit(cdb_valid, cdb_tag, wr_tag)) begin
        rdy_d = 1'b1;
        val_d = cdb_data;
      end else begin
        rdy_d = 1'b0;
      end
    end else if (entry_valid && !rdy_q && cdb_hit(cdb_valid, cdb_tag, tag_q)) begin
      rdy_d = 1'b1;
      val_d = cdb_data;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      val_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      val_q <= val_d;
      rdy_q <= rdy_d;
    end
  end

  assign val = val_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: circular buffer, CDB operand capture, head-only issue.
module mem_issue_queue
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_opcode,
  input  logic [ROB_W-1:0] disp_rob,
  input  logic [3:0]       disp_imm,
  input  logic [7:0]       disp_offset,
  input  logic [4:0]       disp_dest_reg,
  input  logic [7:0]       disp_dest_arch,
  input  logic [TAG_W-1:0] disp_src_tag [NUM_OPS],
  input  logic             disp_src_rdy [NUM_OPS],
  input  logic [VAL_W-1:0] disp_src_val [NUM_OPS],
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [VAL_W-1:0] cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [3:0]       iss_opcode,
  output logic [ROB_W-1:0] iss_rob,
  output logic [3:0]       iss_imm,
  output logic [7:0]       iss_offset,
  output logic [4:0]       iss_dest_reg,
  output logic [7:0]       iss_dest_arch,
  output logic [15:0]      iss_base,
  output logic [VAL_W-1:0] iss_data,
  output logic [PTR_W:0]   count
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  iq_static_t         stat_q [DEPTH];
  iq_static_t         stat_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push, pop;
  logic [VAL_W-1:0]   op_val [DEPTH][NUM_OPS];
  logic [NUM_OPS-1:0] op_rdy [DEPTH];

  // Acceptance looks only at registered occupancy, so a full queue refuses even while popping.
  assign disp_ready = (count_q != (PTR_W+1)'(DEPTH)) && !flush;
  assign push       = disp_valid && disp_ready;
  assign iss_valid  = valid_q[head_q] && (&op_rdy[head_q]);
  assign pop        = iss_valid && iss_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
      mem_iq_operand u_op (
        .clk         (clk),
        .rst         (rst),
        .entry_valid (valid_q[g]),
        .wr_en       (push && (tail_q == PTR_W'(g))),
        .wr_tag      (disp_src_tag[k]),
        .wr_rdy      (disp_src_rdy[k]),
        .wr_val      (disp_src_val[k]),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .val         (op_val[g][k]),
        .rdy         (op_rdy[g][k])
      );
    end
  end

  // Pointer, occupancy and static-field next state; flush discards everything this cycle.
  always_comb begin
    valid_d = valid_q;
    stat_d  = stat_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        stat_d[tail_q]  = '{opcode:    disp_opcode,
                            rob:       disp_rob,
                            imm:       disp_imm,
                            offset:    disp_offset,
                            dest_reg:  disp_dest_reg,
                            dest_arch: disp_dest_arch};
        tail_d          = tail_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  // Control state register; rst outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Static fields are datapath only; validity is tracked separately.
  always_ff @(posedge clk) begin
    stat_q <= stat_d;
  end

  assign iss_opcode    = stat_q[head_q].opcode;
  assign iss_rob       = stat_q[head_q].rob;
  assign iss_imm       = stat_q[head_q].imm;
  assign iss_offset    = stat_q[head_q].offset;
  assign iss_dest_reg  = stat_q[head_q].dest_reg;
  assign iss_dest_arch = stat_q[head_q].dest_arch;
  assign iss_base      = {op_val[head_q][OP_BASE_HI], op_val[head_q][OP_BASE_LO]};
  assign iss_data      = op_val[head_q][OP_DATA];
  assign count         = count_q;

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order scheduler for the memory pipeline: holds dispatched load/store ops, captures operand values from the common data bus (CDB), issues the oldest op once all its operands are ready.
- Sits between rename/dispatch and the memory pipeline.
- Drives the pipeline's valid/ready input handshake; in-order issue preserves load/store ordering without a disambiguation unit.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (mispredict/exception)
- disp_valid  in  1  dispatch op offered
- disp_ready  out  1  queue can accept
- disp_opcode  in  4  memory opcode; bit0=store
- disp_rob  in  5  ROB entry
- disp_imm  in  4  imm; bit3=zero-page wrap mode, passed through
- disp_offset  in  8  address offset
- disp_dest_reg  in  5  physical dest
- disp_dest_arch  in  8  arch dest mask
- disp_src_tag[0..2]  in  3x5  physical tags: base_lo, base_hi, data
- disp_src_rdy[0..2]  in  3x1  operand already available
- disp_src_val[0..2]  in  3x8  value when rdy
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  5  broadcast tag
- cdb_data  in  8  broadcast value
- iss_valid  out  1  head op ready to issue
- iss_ready  in  1  memory pipeline input_ready
- iss_opcode, iss_rob, iss_imm, iss_offset, iss_dest_reg, iss_dest_arch  out  4/5/4/8/5/8  head fields
- iss_base  out  16  {base_hi value, base_lo value}
- iss_data  out  8  data operand value
- count  out  PTR_W+1  occupancy, debug/stall logic

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, named rst.
- State: circular buffer with head/tail pointers (PTR_W bits, natural wrap) and count.
- Per entry: valid; static fields; for each of 3 operands a tag, 8-bit value and rdy bit.
- Reset: head=tail=count=0, all valid=0. Outputs: disp_ready=1, iss_valid=0, count=0; iss_* data fields don't-care.
- Dispatch: disp_ready = (count != DEPTH) & !flush. On disp_valid & disp_ready, write entry at tail, tail++.
  - If disp_src_rdy=0 and cdb_valid with cdb_tag==disp_src_tag in the same cycle, store cdb_data and set rdy=1 (same-cycle bypass). No operand may be lost.
- Wakeup: every cycle, each valid entry operand with rdy=0 and tag==cdb_tag (cdb_valid=1) latches cdb_data and sets rdy. Multiple operands/entries may match one broadcast.
- Issue: combinational from registered head entry.
  - iss_valid = head.valid & all three rdy.
  - Only the head may issue; younger ready entries wait.
  - On iss_valid & iss_ready: clear head.valid, head++.
  - Issued fields come straight from entry storage. Load/store with an unused operand is dispatched with rdy=1.
  - A CDB match on the head in cycle N makes iss_valid=1 in cycle N+1 (one-cycle wakeup latency). No combinational CDB-to-iss path.
- Simultaneous push and pop: both take effect; count unchanged. Full queue does not accept even if popping that cycle (disp_ready depends only on registered count).
- Flush: synchronous, same effect as reset on queue state. Outranks dispatch and issue in that cycle. An issue handshake in the flush cycle is treated as taken by the downstream (pipeline flushes itself).
- rst has priority over flush.
- Backpressure: iss_valid held with all iss_* stable until iss_ready.
- Empty: iss_valid=0.

Decomposition:
- Shared package (mem_pkg): TAG_W=5, ROB_W=5, operand index constants OP_BASE_LO=0, OP_BASE_HI=1, OP_DATA=2, STORE_BIT=0.
- Sub-module mem_iq_operand: one operand slot (tag/value/rdy, dispatch write, CDB capture with bypass), instantiated 3xDEPTH.

Test Plan:
- Reset then dispatch op rob=3 with all rdy=1, base={0x12,0x34}, iss_ready=1 -> iss_valid next cycle, iss_base=0x1234, pops, count 1->0.
- Dispatch A (data tag 7 unready), then B (all ready) -> B not issued. CDB tag 7 data 0x55 -> A issues next cycle with iss_data=0x55, then B.
- Dispatch with base_lo tag 9 unready in the same cycle cdb tag 9 = 0xAB -> entry ready, issues next cycle with base_lo=0xAB.
- Fill 4 entries with iss_ready=0 -> disp_ready=0, count=4, iss_* stable. Raise iss_ready -> 4 pops in order. Pointer wrap on 5th dispatch verified.
- Queue with 3 entries, assert flush with disp_valid=1 -> next cycle count=0, iss_valid=0, dispatched op dropped.
- Assert rst mid-fill with a pending CDB match -> all state cleared, no issue afterwards.
